// File: rtl/alu_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_pkg
// Shared definitions for the sequential shift-and-add multiplier and its ALU:
//   - alu_op_e : 4-bit ALU operation codes understood by alu_mul_seq_alu
//   - state_e  : control FSM state encoding used by alu_mul_seq
//   - DATA_W   : datapath width
// -----------------------------------------------------------------------------
package alu_mul_seq_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_LSL   = 4'b0011,
    ALU_LSR   = 4'b0100,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TEST = 3'd1,
    S_ADD  = 3'd2,
    S_SHL  = 3'd3,
    S_SHR  = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage : alu_mul_seq_pkg

// File: rtl/alu_mul_seq_alu.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_alu
// Purely combinational 64-bit ALU shared by every arithmetic step of the
// multiplier.
// Ports:
//   i_alu_ctrl : operation select (alu_op_e)
//   i_bus_a    : first operand
//   i_bus_b    : second operand / shift amount (low 6 bits) / pass-through value
//   o_bus_w    : result
//   o_zero     : high when o_bus_w is all zeros
// -----------------------------------------------------------------------------
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
(
  input  alu_op_e             i_alu_ctrl,
  input  logic [DATA_W-1:0]   i_bus_a,
  input  logic [DATA_W-1:0]   i_bus_b,
  output logic [DATA_W-1:0]   o_bus_w,
  output logic                o_zero
);

  // NOTE: every output of a combinational block gets a default before the
  // case so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    o_bus_w = '0;
    unique case (i_alu_ctrl)
      ALU_AND:   o_bus_w = i_bus_a & i_bus_b;
      ALU_OR:    o_bus_w = i_bus_a | i_bus_b;
      ALU_ADD:   o_bus_w = i_bus_a + i_bus_b;
      // Shift amount is the low 6 bits of BusB, enough for 0..63.
      ALU_LSL:   o_bus_w = i_bus_a << i_bus_b[5:0];
      ALU_LSR:   o_bus_w = i_bus_a >> i_bus_b[5:0];
      ALU_SUB:   o_bus_w = i_bus_a - i_bus_b;
      ALU_PASSB: o_bus_w = i_bus_b;
      default:   o_bus_w = '0;
    endcase
  end

  assign o_zero = (o_bus_w == '0);

endmodule : alu_mul_seq_alu

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Sequential 64x64 -> 64 (low half) shift-and-add multiplier. One ALU
// instance performs every operation; the FSM walks TEST -> (ADD -> SHL ->
// SHR)* -> DONE, consuming one multiplier bit per ADD/SHL/SHR round and
// stopping as soon as the remaining multiplier is zero.
// Ports:
//   CLK     : clock, all state changes on its rising edge
//   Reset   : synchronous active-high reset
//   Start   : request a multiply, sampled only in IDLE
//   MultA   : multiplicand, captured on the accepting edge
//   MultB   : multiplier, captured on the accepting edge
//   Product : registered low 64 bits of MultA*MultB, held until next request
//   Busy    : high in every state except IDLE
//   Done    : one-cycle pulse while in DONE; Product is valid then
// -----------------------------------------------------------------------------
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [63:0]       MultA,
  input  logic [63:0]       MultB,
  output logic [63:0]       Product,
  output logic              Busy,
  output logic              Done
);

  state_e              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [DATA_W-1:0]   r_product;
  logic                r_busy;
  logic                r_done;

  alu_op_e             w_alu_ctrl;
  logic [DATA_W-1:0]   w_bus_a;
  logic [DATA_W-1:0]   w_bus_b;
  logic [DATA_W-1:0]   w_bus_w;
  logic                w_zero;

  // ALU operand muxing. IDLE and DONE keep the ALU on PassB with zero
  // operands so the op code is always a defined value.
  always_comb begin
    w_alu_ctrl = ALU_PASSB;
    w_bus_a    = '0;
    w_bus_b    = '0;
    unique case (r_state)
      S_TEST: begin
        w_alu_ctrl = ALU_PASSB;
        w_bus_b    = r_mplier;
      end
      S_ADD: begin
        w_alu_ctrl = ALU_ADD;
        w_bus_a    = r_acc;
        w_bus_b    = r_mcand;
      end
      S_SHL: begin
        w_alu_ctrl = ALU_LSL;
        w_bus_a    = r_mcand;
        w_bus_b    = DATA_W'(1);
      end
      S_SHR: begin
        w_alu_ctrl = ALU_LSR;
        w_bus_a    = r_mplier;
        w_bus_b    = DATA_W'(1);
      end
      default: begin
        w_alu_ctrl = ALU_PASSB;
        w_bus_a    = '0;
        w_bus_b    = '0;
      end
    endcase
  end

  alu_mul_seq_alu u_alu (
    .i_alu_ctrl (w_alu_ctrl),
    .i_bus_a    (w_bus_a),
    .i_bus_b    (w_bus_b),
    .o_bus_w    (w_bus_w),
    .o_zero     (w_zero)
  );

  // Control FSM and datapath registers. Busy, Done and Product are registered
  // on the transition into their state so they line up with r_state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_mcand  <= MultA;
            r_mplier <= MultB;
            r_acc    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_TEST;
          end
        end
        S_TEST: begin
          // A zero multiplier skips the loop; acc is already 0.
          if (w_zero) begin
            r_product <= r_acc;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          if (r_mplier[0]) begin
            r_acc <= w_bus_w;
          end
          r_state <= S_SHL;
        end
        S_SHL: begin
          r_mcand <= w_bus_w;
          r_state <= S_SHR;
        end
        S_SHR: begin
          r_mplier <= w_bus_w;
          // Zero here means no set bits remain: acc holds the final product,
          // so latch it now and Product is valid during the Done pulse.
          if (w_zero) begin
            r_product <= r_acc;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_DONE: begin
          // Start is deliberately not looked at here.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Product = r_product;
  assign Busy    = r_busy;
  assign Done    = r_done;

endmodule : alu_mul_seq

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
// Self-checking bench for alu_mul_seq. A cycle-count reference model (product
// computed directly, latency from the bit length of the multiplier) predicts
// Busy, Done and Product; a negedge process compares them every cycle.
// Directed scenarios add literal expectations; a random phase follows.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [63:0] MultA;
  logic [63:0] MultB;
  logic [63:0] Product;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  alu_mul_seq dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Start   (Start),
    .MultA   (MultA),
    .MultB   (MultB),
    .Product (Product),
    .Busy    (Busy),
    .Done    (Done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int bitlen(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) return i + 1;
    end
    return 0;
  endfunction

  bit          m_valid   = 1'b0;
  bit          m_busy    = 1'b0;
  bit          m_done    = 1'b0;
  int          m_cd      = 0;
  logic [63:0] m_pending = '0;
  logic [63:0] m_product = '0;

  // Busy lasts from the accepting edge until 1+3n edges later (Done) plus one.
  always @(posedge CLK) begin
    if (Reset) begin
      m_valid   = 1'b1;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_cd      = 0;
      m_product = '0;
    end else if (m_valid) begin
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_cd--;
        if (m_cd == 0) begin
          m_done    = 1'b1;
          m_product = m_pending;
        end
      end else if (Start) begin
        m_busy    = 1'b1;
        m_pending = MultA * MultB;
        m_cd      = 1 + 3 * bitlen(MultB);
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      check("busy",    {63'd0, Busy}, {63'd0, m_busy});
      check("done",    {63'd0, Done}, {63'd0, m_done});
      check("product", Product, m_product);
    end
  end

  // ------------------------------------------------------------- helpers
  // Called at a negedge with the DUT idle; returns at the negedge after the
  // accepting edge, with operands already scrambled.
  task automatic accept(input logic [63:0] a, input logic [63:0] b);
    Start = 1'b1;
    MultA = a;
    MultB = b;
    @(negedge CLK);
    Start = 1'b0;
    MultA = {$urandom, $urandom};
    MultB = {$urandom, $urandom};
  endtask

  // lat counts clock edges after the accepting edge; -1 on timeout.
  task automatic wait_done(input string name, input int limit, output int lat);
    lat = 0;
    while (!Done && lat < limit) begin
      @(negedge CLK);
      lat++;
    end
    if (!Done) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      lat = -1;
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int lat;
    int pulses;
    Reset = 1'b1;
    Start = 1'b0;
    MultA = '0;
    MultB = '0;

    // Reset held two cycles
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    check("rst_product", Product, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    pulses = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      if (Done) pulses++;
    end
    check("idle_no_done", 64'(pulses), 64'd0);

    // 3 * 5
    accept(64'd3, 64'd5);
    check("busy_after_accept", {63'd0, Busy}, 64'd1);
    wait_done("mul3x5", 300, lat);
    check("lat_3x5", 64'(lat), 64'd10);
    check("prod_3x5", Product, 64'd15);
    @(negedge CLK);

    // all-ones * 0
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    wait_done("mulx0", 300, lat);
    check("lat_x0", 64'(lat), 64'd1);
    check("prod_x0", Product, 64'd0);
    @(negedge CLK);

    // all-ones * 2^63, worst-case latency and wrap
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    wait_done("mulmax", 300, lat);
    check("lat_max", 64'(lat), 64'd193);
    check("prod_max", Product, 64'h8000_0000_0000_0000);
    @(negedge CLK);

    // 7 * 6 with Start re-asserted mid-operation and during DONE
    accept(64'd7, 64'd6);
    pulses = 0;
    lat    = -1;
    for (int j = 0; j < 40; j++) begin
      if (Done) begin
        pulses++;
        lat = j;
      end
      Start = (j == 3 || j == 10);
      MultA = 64'd2;
      MultB = 64'd2;
      @(negedge CLK);
    end
    Start = 1'b0;
    check("ignored_pulses", 64'(pulses), 64'd1);
    check("ignored_lat", 64'(lat), 64'd10);
    check("ignored_prod", Product, 64'd42);
    check("ignored_idle", {63'd0, Busy}, 64'd0);

    // 9 * 0xFF aborted by reset in cycle 12
    accept(64'd9, 64'hFF);
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      if (Done) pulses++;
      if (j == 13) begin
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_product", Product, 64'd0);
      end
      Reset = (j == 12);
      @(negedge CLK);
    end
    Reset = 1'b0;
    check("abort_no_done", 64'(pulses), 64'd0);
    accept(64'd4, 64'd4);
    wait_done("mul4x4", 300, lat);
    check("lat_4x4", 64'(lat), 64'd10);
    check("prod_4x4", Product, 64'd16);
    @(negedge CLK);

    // Random phase: operands, Start and rare resets every cycle
    for (int k = 0; k < 6000; k++) begin
      Start = ($urandom_range(3) == 0);
      Reset = ($urandom_range(299) == 0);
      MultA = {$urandom, $urandom};
      MultB = {$urandom, $urandom} >> $urandom_range(64);
      @(negedge CLK);
    end
    Start = 1'b0;
    Reset = 1'b0;
    repeat (200) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_alu_mul_seq
